// File: rtl/rv32_muldiv_seq.sv
// Iterative RV32 M-extension unit: shift-add multiply and restoring divide, one bit per cycle,
// with fast-path divide-by-zero / signed-overflow results and a valid/ready result handshake.
`timescale 1ns/1ps
module rv32_muldiv_seq #(
    parameter int XLEN         = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [2:0]              i_funct3,
    input  logic [XLEN-1:0]         i_rs1,
    input  logic [XLEN-1:0]         i_rs2,
    input  logic [RegAddrWidth-1:0] i_rd,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [XLEN-1:0]         o_result,
    output logic [RegAddrWidth-1:0] o_rd
);

    localparam int                  CntWidth = $clog2(XLEN);
    localparam logic [CntWidth-1:0] LastIter = CntWidth'(XLEN - 1);

    typedef enum logic [2:0] {Idle, Mul, Div, Fix, Done} stateE;

    stateE               state, stateNext;
    logic [CntWidth-1:0] iterCount;
    logic [XLEN-1:0]     accHi, accLo, opB;
    logic [2:0]          funct3Q;
    logic                negMain, negRem;

    logic                isDivOp, rs1Signed, rs2Signed, rs1Neg, rs2Neg;
    logic [XLEN-1:0]     rs1Mag, rs2Mag, fastResult;
    logic                divByZero, divOverflow, fastPath, accept;

    logic [XLEN:0]       mulSum, divShift, divDiff;
    logic                divFits;
    logic [2*XLEN-1:0]   productFixed;
    logic [XLEN-1:0]     quotientFixed, remainderFixed, fixResult;

    assign isDivOp = i_funct3[2];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        rs1Signed = 1'b0;
        rs2Signed = 1'b0;
        case (i_funct3)
            3'b001:         begin rs1Signed = 1'b1; rs2Signed = 1'b1; end  // MULH
            3'b010:         rs1Signed = 1'b1;                              // MULHSU
            3'b100, 3'b110: begin rs1Signed = 1'b1; rs2Signed = 1'b1; end  // DIV, REM
            default:        ;
        endcase
    end

    assign rs1Neg = rs1Signed & i_rs1[XLEN-1];
    assign rs2Neg = rs2Signed & i_rs2[XLEN-1];
    assign rs1Mag = rs1Neg ? -i_rs1 : i_rs1;
    assign rs2Mag = rs2Neg ? -i_rs2 : i_rs2;

    assign divByZero   = isDivOp & (i_rs2 == '0);
    assign divOverflow = isDivOp & ~i_funct3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2);
    assign fastPath    = divByZero | divOverflow;

    // funct3[1] separates REM/REMU from DIV/DIVU on the fast path.
    always_comb begin
        fastResult = '0;
        if (divByZero) fastResult = i_funct3[1] ? i_rs1 : '1;
        else           fastResult = i_funct3[1] ? '0 : i_rs1;
    end

    assign o_ready = (state == Idle) & ~i_flush;
    assign accept  = i_valid & o_ready;

    always_comb begin
        stateNext = state;
        o_valid   = 1'b0;
        case (state)
            Idle:     if (accept) stateNext = fastPath ? Done : (isDivOp ? Div : Mul);
            Mul, Div: if (iterCount == LastIter) stateNext = Fix;
            Fix:      stateNext = Done;
            Done: begin
                o_valid = 1'b1;
                if (i_ready) stateNext = Idle;
            end
            default:  stateNext = Idle;
        endcase
        if (i_flush) stateNext = Idle;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= Idle;
        else        state <= stateNext;
    end

    // Multiply: {accHi, accLo} shifts right; accLo starts as the multiplier magnitude.
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);

    // Divide: accHi is the partial remainder, accLo shifts dividend bits out and quotient bits in.
    assign divShift = {accHi, accLo[XLEN-1]};
    assign divDiff  = divShift - {1'b0, opB};
    assign divFits  = ~divDiff[XLEN];

    assign productFixed   = negMain ? -{accHi, accLo} : {accHi, accLo};
    assign quotientFixed  = negMain ? -accLo : accLo;
    assign remainderFixed = negRem  ? -accHi : accHi;

    always_comb begin
        fixResult = remainderFixed;
        case (funct3Q)
            3'b000:                 fixResult = productFixed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fixResult = productFixed[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fixResult = quotientFixed;
            default:                fixResult = remainderFixed;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iterCount <= '0;
            accHi     <= '0;
            accLo     <= '0;
            opB       <= '0;
            funct3Q   <= '0;
            negMain   <= 1'b0;
            negRem    <= 1'b0;
            o_result  <= '0;
            o_rd      <= '0;
        end else begin
            case (state)
                Idle: if (accept) begin
                    iterCount <= '0;
                    accHi     <= '0;
                    accLo     <= isDivOp ? rs1Mag : rs2Mag;
                    opB       <= isDivOp ? rs2Mag : rs1Mag;
                    funct3Q   <= i_funct3;
                    negMain   <= rs1Neg ^ rs2Neg;
                    negRem    <= rs1Neg;
                    o_rd      <= i_rd;
                    if (fastPath) o_result <= fastResult;
                end
                Mul: begin
                    accHi <= mulSum[XLEN:1];
                    accLo <= {mulSum[0], accLo[XLEN-1:1]};
                    if (iterCount != LastIter) iterCount <= iterCount + 1'b1;
                end
                Div: begin
                    accHi <= divFits ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
                    accLo <= {accLo[XLEN-2:0], divFits};
                    if (iterCount != LastIter) iterCount <= iterCount + 1'b1;
                end
                Fix:     o_result <= fixResult;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rv32_muldiv_seq.md
Name: rv32_muldiv_seq

Overview:
- Iterative sequencer and datapath for the RV32 M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the execute-stage ALU. Decode steers OpAluR instructions with funct7 = 0000001 here.
- Produces one result per operation through a valid/ready handshake, using a 1-bit-per-cycle shift-add / restoring-divide engine.
- Handles the RISC-V divide-by-zero and signed-overflow cases on a fast path.

Parameters:
- XLEN, 32, operand/result width (matches RegWidth).
- RegAddrWidth, 5, destination register tag width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  operation request.
- o_ready  out  1  sequencer can accept; equals (state==IDLE) & ~i_flush.
- i_funct3  in  3  M-extension funct3 (000 MUL … 111 REMU).
- i_rs1  in  XLEN  operand A (multiplicand / dividend).
- i_rs2  in  XLEN  operand B (multiplier / divisor).
- i_rd  in  RegAddrWidth  destination tag, returned unchanged.
- i_flush  in  1  pipeline flush; aborts any operation.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  result.
- o_rd  out  RegAddrWidth  destination tag of o_result.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values (rst_n low at an edge): state=IDLE, o_valid=0, o_result=0, o_rd=0, iteration counter=0, internal accumulators=0.
- States:
  - IDLE
  - MUL (XLEN iterations)
  - DIV (XLEN iterations)
  - FIX (sign correction, 1 cycle)
  - DONE
- Accept: the edge where i_valid & o_ready. Operands, funct3 and rd are latched at that edge.
- Operand preparation at accept:
  - Signed operands are replaced by their magnitudes; the operation's sign flags are latched.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MUL/MULHU: both unsigned (low word is sign-independent).
  - DIV/REM: both signed.
  - DIVU/REMU: both unsigned.
- Transitions out of IDLE on accept:
  - Divide-type op with rs2==0 → DONE. Quotient = all ones; remainder = rs1 (unmodified).
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF → DONE. DIV result 0x80000000, REM result 0.
  - Otherwise mul-type → MUL, divide-type → DIV, counter=0.
- MUL state: each cycle adds the shifted multiplicand if the current multiplier bit is set; 2·XLEN-bit product; counter++. After iteration XLEN-1 → FIX.
- DIV state: restoring step per cycle (shift remainder left, bring in next dividend MSB, subtract divisor if no borrow, set quotient bit). After iteration XLEN-1 → FIX.
- FIX state, one cycle, then → DONE with o_result registered:
  - Product negated (2·XLEN-bit two's complement) if the sign flags differ.
  - Quotient negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Result selection: MUL → low word; MULH/MULHSU/MULHU → high word; DIV/DIVU → quotient; REM/REMU → remainder.
- Latency:
  - Normal path: o_valid first high in cycle accept+XLEN+2 (34 for XLEN=32).
  - Fast path: o_valid high in cycle accept+1.
- DONE state: o_valid=1; o_result and o_rd held stable until i_valid-independent i_ready=1. At that edge → IDLE, o_valid=0. No new op is accepted in DONE; back-to-back throughput is one op per latency+1 cycles minimum.
- Flush: i_flush=1 at an edge in any state → IDLE, o_valid=0, result discarded.
  - i_flush takes priority over i_ready and over acceptance; o_ready is low while i_flush=1.
- Reset mid-operation behaves identically to reset from IDLE.
- Input changes on i_rs1/i_rs2/i_funct3 after accept have no effect.
- Counter width is $clog2(XLEN); the counter never wraps past XLEN-1.

Test Plan:
- MUL 7×(−3): rs1=7, rs2=0xFFFFFFFD → o_result=0xFFFFFFEB, o_valid in cycle 34; MULHU same operands → 0x00000006; MULH → 0xFFFFFFFF.
- DIV −20/3: rs1=0xFFFFFFEC, rs2=3 → DIV 0xFFFFFFFA, REM 0xFFFFFFFE; DIVU 100/7 → 14, REMU → 2; rd=9 returned on o_rd.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, both with o_valid in cycle accept+1. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Backpressure: hold i_ready=0 for 10 cycles in DONE → o_result/o_rd stable and o_ready=0; i_valid pulses ignored; i_ready=1 → IDLE next cycle.
- Flush: assert i_flush at cycle 15 of a DIV → o_valid never rises, o_ready=1 the next cycle; a flush coinciding with i_valid in IDLE → no accept.
- Reset: drive rst_n=0 for one edge mid-MUL → all outputs 0 and state IDLE; a new MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF then completes with 0xFFFFFFFF.
